// File: rtl/chan_reorder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// chan_reorder
//
// Frame-aligning reorder buffer that sits directly after the polyphase
// filterbank. It gathers N consecutive filterbank outputs (one per arm) into one
// half of a ping-pong RAM. Each complete frame is then replayed as a single
// gap-free burst, which the FFT stage that follows consumes directly.
//
// Build option:
//   CHAN_REORDER_BITREV_EN  defined   -> frames are replayed in bit-reversed
//                                        index order (N=8: 0,4,2,6,1,5,3,7)
//                           undefined -> frames are replayed in natural order
//   Latency and throughput are the same in both builds.
//
// Ports:
//   clk        clock
//   rst_n      synchronous, active-low reset; drops all buffered data
//   in_data    sample from the filterbank
//   in_nd      in_data / in_m / in_first valid this cycle
//   in_m       meta carried alongside in_data
//   in_first   sample is arm 0 (frame start); may be tied low
//   out_data   reordered sample (holds its value while out_nd is low)
//   out_nd     out_data valid
//   out_m      meta travelling with out_data
//   out_first  first sample of an output frame
//   error      sticky framing error (resync or bank overflow)
// -----------------------------------------------------------------------------
module chan_reorder #(
    parameter int N      = 8,
    parameter int WIDTH  = 32,
    parameter int MWIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_nd,
    input  logic [MWIDTH-1:0] in_m,
    input  logic              in_first,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_nd,
    output logic [MWIDTH-1:0] out_m,
    output logic              out_first,
    output logic              error
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int EW = MWIDTH + WIDTH;

    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Replay order of frame slot idx.
    function automatic logic [AW-1:0] rd_map(input logic [AW-1:0] idx);
        logic [AW-1:0] r;
        r = {AW{1'b0}};
`ifdef CHAN_REORDER_BITREV_EN
        for (int b = 0; b < AW; b++) begin
            r[b] = idx[AW-1-b];
        end
`else
        r = idx;
`endif
        return r;
    endfunction

    // Ping-pong storage of {meta, data}; never reset, guarded by the full flags.
    logic [EW-1:0]     mem_q [2][N];

    logic [AW-1:0]     wr_idx_q,  wr_idx_d;
    logic              wr_bank_q, wr_bank_d;
    logic [1:0]        full_q,    full_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic [AW-1:0]     rd_idx_q,  rd_idx_d;
    logic              rd_bank_q, rd_bank_d;
    logic              error_q,   error_d;

    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [MWIDTH-1:0] out_m_q,     out_m_d;
    logic              out_nd_q,    out_nd_d;
    logic              out_first_q, out_first_d;

    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s;
    logic              wr_done_s;
    logic              resync_s;
    logic              rd_fire_s;
    logic              rd_clear_s;
    logic [EW-1:0]     rd_word_s;

    // Write side: slot addressing, frame completion and arm-0 resync.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_idx_q;
        wr_done_s = 1'b0;
        resync_s  = 1'b0;
        if (in_nd) begin
            wr_en_s = 1'b1;
            if (in_first && (wr_idx_q != IDX_ZERO)) begin
                // Arm 0 arrived early: drop the partial frame and restart it
                // in the same bank with this sample in slot 0.
                resync_s  = 1'b1;
                wr_addr_s = IDX_ZERO;
                wr_idx_d  = IDX_ONE;
            end else if (wr_idx_q == IDX_LAST) begin
                wr_idx_d  = IDX_ZERO;
                wr_bank_d = ~wr_bank_q;
                wr_done_s = 1'b1;
            end else begin
                wr_idx_d  = wr_idx_q + IDX_ONE;
            end
        end else begin
            wr_idx_d = wr_idx_q;
        end
    end

    // Read side: slot 0 is issued in the same cycle the FSM leaves IDLE so that
    // output starts two cycles after the last write of a frame; a burst that
    // ends with the other bank still filling drops to IDLE for one cycle, which
    // lines up exactly with that bank becoming full, keeping output gap-free.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_bank_d  = rd_bank_q;
        rd_fire_s  = 1'b0;
        rd_clear_s = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_fire_s = 1'b1;
                end else begin
                    rd_fire_s = 1'b0;
                end
            end
            RD_READ: begin
                rd_fire_s = 1'b1;
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
        if (rd_fire_s) begin
            if (rd_idx_q == IDX_LAST) begin
                rd_clear_s = 1'b1;
                rd_idx_d   = IDX_ZERO;
                rd_bank_d  = ~rd_bank_q;
                rd_state_d = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
            end else begin
                rd_idx_d   = rd_idx_q + IDX_ONE;
                rd_state_d = RD_READ;
            end
        end else begin
            rd_idx_d = rd_idx_q;
        end
    end

    // Bank-full flags and sticky error; on a same-bank clash the set wins.
    always_comb begin
        full_d = full_q;
        if (rd_clear_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d = full_d;
        end
        if (wr_done_s) begin
            full_d[wr_bank_q] = 1'b1;
        end else begin
            full_d = full_d;
        end
        error_d = error_q | resync_s | (wr_done_s & full_q[wr_bank_q]);
    end

    // Output stage: data/meta hold while idle, first flag only with valid.
    always_comb begin
        rd_word_s   = mem_q[rd_bank_q][rd_map(rd_idx_q)];
        out_nd_d    = rd_fire_s;
        out_first_d = rd_fire_s & (rd_idx_q == IDX_ZERO);
        if (rd_fire_s) begin
            out_data_d = rd_word_s[WIDTH-1:0];
            out_m_d    = rd_word_s[EW-1:WIDTH];
        end else begin
            out_data_d = out_data_q;
            out_m_d    = out_m_q;
        end
    end

    // Sample storage write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_bank_q][wr_addr_s] <= {in_m, in_data};
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx_q    <= IDX_ZERO;
            wr_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            rd_state_q  <= RD_IDLE;
            rd_idx_q    <= IDX_ZERO;
            rd_bank_q   <= 1'b0;
            error_q     <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_m_q     <= {MWIDTH{1'b0}};
            out_nd_q    <= 1'b0;
            out_first_q <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            rd_state_q  <= rd_state_d;
            rd_idx_q    <= rd_idx_d;
            rd_bank_q   <= rd_bank_d;
            error_q     <= error_d;
            out_data_q  <= out_data_d;
            out_m_q     <= out_m_d;
            out_nd_q    <= out_nd_d;
            out_first_q <= out_first_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_m     = out_m_q;
    assign out_nd    = out_nd_q;
    assign out_first = out_first_q;
    assign error     = error_q;

endmodule

// File: tb/tb_chan_reorder.sv
`timescale 1ns/1ps
// Directed testbench for chan_reorder (N=8, WIDTH=32, MWIDTH=1).
// Expected replay order follows the build: bit-reversed when
// CHAN_REORDER_BITREV_EN is defined, natural order otherwise.
module tb_chan_reorder;

`ifdef CHAN_REORDER_BITREV_EN
    localparam int MAP [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    localparam int MAP [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic        f;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_nd;
    logic [0:0]  in_m;
    logic        in_first;
    logic [31:0] out_data;
    logic        out_nd;
    logic [0:0]  out_m;
    logic        out_first;
    logic        error;

    int   n_tests;
    int   n_fail;
    int   cyc;
    int   last_in_cyc;
    exp_t exp_q[$];
    int   out_cyc_q[$];

    chan_reorder #(.N(8), .WIDTH(32), .MWIDTH(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_nd     (in_nd),
        .in_m      (in_m),
        .in_first  (in_first),
        .out_data  (out_data),
        .out_nd    (out_nd),
        .out_m     (out_m),
        .out_first (out_first),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_nd === 1'b1) begin
            out_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_eq("spurious_nd", 64'(out_nd), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("out_data",  64'(out_data),  64'(e.d));
                check_eq("out_m",     64'(out_m),     64'(e.m));
                check_eq("out_first", 64'(out_first), 64'(e.f));
            end
        end else begin
            check_eq("first_idle", 64'(out_first), 64'd0);
        end
    end

    function automatic logic meta_of(input logic [31:0] d);
        return d[1];
    endfunction

    task automatic expect_frame(input int base);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.d = 32'(base + MAP[i]);
            e.m = meta_of(e.d);
            e.f = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic first);
        in_nd       = 1'b1;
        in_data     = d;
        in_m        = meta_of(d);
        in_first    = first;
        last_in_cyc = cyc;
        @(posedge clk); #1;
        in_nd    = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < 8; i++) send(32'(base + i), i == 0);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    function automatic bit contig(input int start, input int len);
        if (out_cyc_q.size() < start + len) return 1'b0;
        for (int i = 1; i < len; i++)
            if (out_cyc_q[start + i] != out_cyc_q[start] + i) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        exp_q.delete();
        out_cyc_q.delete();
    endtask

    // Case 1 shape: one frame, latency 2, 8-cycle burst, hold afterwards.
    task automatic single_frame(input string tag);
        int lat_ref;
        out_cyc_q.delete();
        expect_frame(0);
        send_frame(0);
        lat_ref = last_in_cyc + 2;
        drain({tag, "_drain"});
        idle(2);
        check_eq({tag, "_count"},   64'(out_cyc_q.size()), 64'd8);
        check_eq({tag, "_latency"}, 64'(out_cyc_q.size() > 0 ? out_cyc_q[0] : -1), 64'(lat_ref));
        check_eq({tag, "_contig"},  64'(contig(0, 8)), 64'd1);
        check_eq({tag, "_hold_d"},  64'(out_data), 64'd7);
        check_eq({tag, "_hold_m"},  64'(out_m), 64'd1);
        check_eq({tag, "_error"},   64'(error), 64'd0);
    endtask

    int gaps [16] = '{2, 0, 3, 1, 0, 2, 4, 1, 0, 3, 2, 0, 1, 2, 3, 0};

    initial begin
        int lat_ref;
        int cnt;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        in_data  = 32'd0;
        in_nd    = 1'b0;
        in_m     = 1'b0;
        in_first = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        check_eq("rst_out_nd",    64'(out_nd),    64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_out_m",     64'(out_m),     64'd0);
        check_eq("rst_out_first", 64'(out_first), 64'd0);
        check_eq("rst_error",     64'(error),     64'd0);

        // Case 1: single frame
        single_frame("c1");

        // Case 2: three frames back-to-back
        out_cyc_q.delete();
        expect_frame(0);
        expect_frame(8);
        expect_frame(16);
        for (int f = 0; f < 3; f++) begin
            send_frame(f * 8);
            if (f == 0) lat_ref = last_in_cyc + 2;
        end
        drain("c2_drain");
        idle(2);
        check_eq("c2_count",   64'(out_cyc_q.size()), 64'd24);
        check_eq("c2_latency", 64'(out_cyc_q.size() > 0 ? out_cyc_q[0] : -1), 64'(lat_ref));
        check_eq("c2_contig",  64'(contig(0, 24)), 64'd1);
        check_eq("c2_error",   64'(error), 64'd0);

        // Case 3: sparse input, 16 samples
        out_cyc_q.delete();
        expect_frame(32);
        expect_frame(40);
        for (int i = 0; i < 16; i++) begin
            idle(gaps[i]);
            send(32'(32 + i), (i % 8) == 0);
        end
        drain("c3_drain");
        idle(2);
        check_eq("c3_count",   64'(out_cyc_q.size()), 64'd16);
        check_eq("c3_burst0",  64'(contig(0, 8)), 64'd1);
        check_eq("c3_burst1",  64'(contig(8, 8)), 64'd1);
        check_eq("c3_error",   64'(error), 64'd0);

        // Case 4: early arm-0 resync
        out_cyc_q.delete();
        expect_frame(100);
        for (int i = 0; i < 5; i++) send(32'(i), i == 0);
        check_eq("c4_err_before", 64'(error), 64'd0);
        send(32'd100, 1'b1);
        check_eq("c4_err_after", 64'(error), 64'd1);
        for (int i = 1; i < 8; i++) send(32'(100 + i), 1'b0);
        drain("c4_drain");
        idle(4);
        check_eq("c4_count",  64'(out_cyc_q.size()), 64'd8);
        check_eq("c4_sticky", 64'(error), 64'd1);

        // Case 5: reset during the 4th output cycle of a burst
        do_reset();
        check_eq("c5_err_clr", 64'(error), 64'd0);
        expect_frame(200);
        send_frame(200);
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 4; i++) begin
            @(posedge clk); #1;
            if (out_nd === 1'b1) cnt++;
        end
        check_eq("c5_burst_seen", 64'(cnt), 64'd4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("c5_out_nd",    64'(out_nd),    64'd0);
        check_eq("c5_out_data",  64'(out_data),  64'd0);
        check_eq("c5_out_m",     64'(out_m),     64'd0);
        check_eq("c5_out_first", 64'(out_first), 64'd0);
        check_eq("c5_left",      64'(exp_q.size()), 64'd4);
        exp_q.delete();
        out_cyc_q.delete();
        idle(12);
        check_eq("c5_no_tail", 64'(out_cyc_q.size()), 64'd0);
        single_frame("c5_fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
